// File: rtl/mem_stage_lat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lat_pkg
// Description : Shared definitions for the latency-aware memory/write-back
//               stage: FSM state encoding and load-latency bounds.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_lat_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Largest supported load latency, and the counter width needed to reach it.
  localparam int unsigned MEM_LAT_MAX = 15;
  localparam int unsigned LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage
`default_nettype wire

// File: rtl/mem_stage_lat_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments on i_inc and sticks at all-ones.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset, clears the count
//               i_inc   - increment request for this cycle
//               o_count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_lat.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lat
// Description : Memory/write-back stage for a data memory with MEM_LAT-cycle
//               read latency. Loads stall upstream until data returns;
//               stores and ALU ops complete in one cycle. Write-back data,
//               destination and strobe are registered. Stall cycles are
//               counted in a saturating performance counter.
// Ports       : Clk, Rst (async, active-high)
//               EX side  : ALUResult, memAddr, storeData, memEnab,
//                          memWriteEnab, sel_mem2reg, regWrite_in, regAddr_in
//               Memory   : dm_rdata (in), dm_en, dm_we, dm_addr, dm_wdata
//               Pipeline : stall
//               WB side  : WB_writeData, WB_regAddr, WB_regWrite
//               Perf     : stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lat
  import mem_stage_lat_pkg::*;
#(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned ASIZE   = 10,
  parameter int unsigned RSIZE   = 3,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [DSIZE-1:0] ALUResult,
  input  logic [ASIZE-1:0] memAddr,
  input  logic [DSIZE-1:0] storeData,
  input  logic             memEnab,
  input  logic             memWriteEnab,
  input  logic             sel_mem2reg,
  input  logic             regWrite_in,
  input  logic [RSIZE-1:0] regAddr_in,
  input  logic [DSIZE-1:0] dm_rdata,
  output logic             dm_en,
  output logic             dm_we,
  output logic [ASIZE-1:0] dm_addr,
  output logic [DSIZE-1:0] dm_wdata,
  output logic             stall,
  output logic [DSIZE-1:0] WB_writeData,
  output logic [RSIZE-1:0] WB_regAddr,
  output logic             WB_regWrite,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [LAT_W-1:0] LAT_V = LAT_W'(MEM_LAT);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [DSIZE-1:0] wb_data_q, wb_data_d;
  logic [RSIZE-1:0] wb_addr_q, wb_addr_d;
  logic             wb_we_q, wb_we_d;

  logic is_load;
  logic lat_done;
  logic stall_raw;
  logic dm_en_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_we_d   = wb_we_q;

    is_load   = memEnab & ~memWriteEnab;
    lat_done  = (state_q == ST_WAIT) && (cnt_q == LAT_V);
    stall_raw = ((state_q == ST_IDLE) & is_load) |
                ((state_q == ST_WAIT) & ~lat_done);
    // Memory is only touched from IDLE; in WAIT the held inputs must not
    // re-issue the same access.
    dm_en_raw = (state_q == ST_IDLE) & memEnab;

    case (state_q)
      ST_IDLE: begin
        if (is_load) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lat_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Inputs are frozen while stalled, so suppress the strobe to avoid
    // writing the register file more than once per instruction.
    if (stall_raw) begin
      wb_we_d = 1'b0;
    end else begin
      wb_data_d = (lat_done | sel_mem2reg) ? dm_rdata : ALUResult;
      wb_addr_d = regAddr_in;
      wb_we_d   = regWrite_in;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_we_q   <= wb_we_d;
    end
  end

  // Gate the combinational controls with reset so they drop the moment
  // reset asserts, even if upstream still presents a load.
  assign stall    = stall_raw & ~Rst;
  assign dm_en    = dm_en_raw & ~Rst;
  assign dm_we    = dm_en & memWriteEnab;
  assign dm_addr  = memAddr;
  assign dm_wdata = storeData;

  assign WB_writeData = wb_data_q;
  assign WB_regAddr   = wb_addr_q;
  assign WB_regWrite  = wb_we_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (Clk),
    .rst     (Rst),
    .i_inc   (stall),
    .o_count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lat.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lat
// Description : Self-checking bench for mem_stage_lat. Three instances share
//               one set of inputs: MEM_LAT=3, MEM_LAT=1, and MEM_LAT=3 with a
//               4-bit stall counter. Each test starts from reset and checks
//               only the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lat;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] ALUResult = '0;
  logic [9:0]  memAddr = '0;
  logic [15:0] storeData = '0;
  logic        memEnab = 1'b0;
  logic        memWriteEnab = 1'b0;
  logic        sel_mem2reg = 1'b0;
  logic        regWrite_in = 1'b0;
  logic [2:0]  regAddr_in = '0;
  logic [15:0] dm_rdata = '0;

  logic        en3, we3, st3, wbw3;
  logic [9:0]  ad3;
  logic [15:0] wd3, wbd3, sc3;
  logic [2:0]  wba3;

  logic        en1, we1, st1, wbw1;
  logic [9:0]  ad1;
  logic [15:0] wd1, wbd1, sc1;
  logic [2:0]  wba1;

  logic        enc, wec, stc, wbwc;
  logic [9:0]  adc;
  logic [15:0] wdc, wbdc;
  logic [3:0]  scc;
  logic [2:0]  wbac;

  always #5 Clk = ~Clk;

  mem_stage_lat #(.MEM_LAT(3)) u_lat3 (
    .Clk(Clk), .Rst(Rst), .ALUResult(ALUResult), .memAddr(memAddr),
    .storeData(storeData), .memEnab(memEnab), .memWriteEnab(memWriteEnab),
    .sel_mem2reg(sel_mem2reg), .regWrite_in(regWrite_in), .regAddr_in(regAddr_in),
    .dm_rdata(dm_rdata), .dm_en(en3), .dm_we(we3), .dm_addr(ad3), .dm_wdata(wd3),
    .stall(st3), .WB_writeData(wbd3), .WB_regAddr(wba3), .WB_regWrite(wbw3),
    .stall_cnt(sc3));

  mem_stage_lat #(.MEM_LAT(1)) u_lat1 (
    .Clk(Clk), .Rst(Rst), .ALUResult(ALUResult), .memAddr(memAddr),
    .storeData(storeData), .memEnab(memEnab), .memWriteEnab(memWriteEnab),
    .sel_mem2reg(sel_mem2reg), .regWrite_in(regWrite_in), .regAddr_in(regAddr_in),
    .dm_rdata(dm_rdata), .dm_en(en1), .dm_we(we1), .dm_addr(ad1), .dm_wdata(wd1),
    .stall(st1), .WB_writeData(wbd1), .WB_regAddr(wba1), .WB_regWrite(wbw1),
    .stall_cnt(sc1));

  mem_stage_lat #(.MEM_LAT(3), .CNT_W(4)) u_cnt4 (
    .Clk(Clk), .Rst(Rst), .ALUResult(ALUResult), .memAddr(memAddr),
    .storeData(storeData), .memEnab(memEnab), .memWriteEnab(memWriteEnab),
    .sel_mem2reg(sel_mem2reg), .regWrite_in(regWrite_in), .regAddr_in(regAddr_in),
    .dm_rdata(dm_rdata), .dm_en(enc), .dm_we(wec), .dm_addr(adc), .dm_wdata(wdc),
    .stall(stc), .WB_writeData(wbdc), .WB_regAddr(wbac), .WB_regWrite(wbwc),
    .stall_cnt(scc));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive_nop();
    ALUResult = '0; memAddr = '0; storeData = '0; memEnab = 1'b0;
    memWriteEnab = 1'b0; sel_mem2reg = 1'b0; regWrite_in = 1'b0;
    regAddr_in = '0; dm_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    drive_nop();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] alu;
    logic [9:0]  addr;
    logic [15:0] sdata;
    logic        en;
    logic        we;
    logic        rw;
    logic [2:0]  ra;
    logic        x_dm_en;
    logic        x_dm_we;
    logic [15:0] x_wbd;
    logic [2:0]  x_wba;
    logic        x_wbw;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // ALU op, store to top address, another ALU op, idle, store to address 0
    vecs[0] = '{16'h1234, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 16'h1234, 3'd5, 1'b1};
    vecs[1] = '{16'h0000, 10'h3FF, 16'hA5A5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000, 3'd0, 1'b0};
    vecs[2] = '{16'hFFFF, 10'h155, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 16'hFFFF, 3'd7, 1'b1};
    vecs[3] = '{16'h0000, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    vecs[4] = '{16'h0042, 10'h000, 16'h5A5A, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 16'h0042, 3'd3, 1'b0};

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_stall", st3, 0);
    check("rst_dm_en", en3, 0);
    check("rst_wbd", wbd3, 0);
    check("rst_wbw", wbw3, 0);
    check("rst_cnt", sc3, 0);

    // ---------------- table: single-cycle ops on MEM_LAT=3 ----------------
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      ALUResult = vecs[i].alu; memAddr = vecs[i].addr; storeData = vecs[i].sdata;
      memEnab = vecs[i].en; memWriteEnab = vecs[i].we; sel_mem2reg = 1'b0;
      regWrite_in = vecs[i].rw; regAddr_in = vecs[i].ra;
      #1;
      check($sformatf("v%0d_stall", i), st3, 0);
      check($sformatf("v%0d_dm_en", i), en3, vecs[i].x_dm_en);
      check($sformatf("v%0d_dm_we", i), we3, vecs[i].x_dm_we);
      check($sformatf("v%0d_addr", i), ad3, vecs[i].addr);
      check($sformatf("v%0d_wdata", i), wd3, vecs[i].sdata);
      @(posedge Clk); #1;
      check($sformatf("v%0d_wbd", i), wbd3, vecs[i].x_wbd);
      check($sformatf("v%0d_wba", i), wba3, vecs[i].x_wba);
      check($sformatf("v%0d_wbw", i), wbw3, vecs[i].x_wbw);
    end
    @(negedge Clk);
    drive_nop();
    #1;
    check("tbl_dm_en_drop", en3, 0);
    check("tbl_stall_cnt", sc3, 0);

    // ---------------- MEM_LAT=3 load ----------------
    do_reset();
    memEnab = 1'b1; memWriteEnab = 1'b0; sel_mem2reg = 1'b1;
    memAddr = 10'h040; regWrite_in = 1'b1; regAddr_in = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("ld3_c%0d_stall", c), st3, 1);
      check($sformatf("ld3_c%0d_dm_en", c), en3, (c == 0) ? 1 : 0);
      check($sformatf("ld3_c%0d_dm_we", c), we3, 0);
      check($sformatf("ld3_c%0d_addr", c), ad3, 10'h040);
      @(posedge Clk); #1;
      check($sformatf("ld3_c%0d_wbw", c), wbw3, 0);
      @(negedge Clk);
    end
    dm_rdata = 16'hBEEF;
    #1;
    check("ld3_c3_stall", st3, 0);
    check("ld3_c3_dm_en", en3, 0);
    @(posedge Clk); #1;
    check("ld3_wbd", wbd3, 16'hBEEF);
    check("ld3_wba", wba3, 2);
    check("ld3_wbw", wbw3, 1);
    check("ld3_cnt", sc3, 3);
    @(negedge Clk);
    drive_nop();
    #1;
    check("ld3_after_stall", st3, 0);

    // ---------------- reset mid-WAIT (cnt=2) ----------------
    do_reset();
    memEnab = 1'b1; sel_mem2reg = 1'b1; regWrite_in = 1'b1; regAddr_in = 3'd4;
    memAddr = 10'h010;
    @(posedge Clk); @(posedge Clk); #2;  // now WAIT with cnt=2
    check("mid_pre_stall", st3, 1);
    check("mid_pre_cnt", sc3, 2);
    Rst = 1'b1;
    #1;
    check("mid_rst_stall", st3, 0);
    check("mid_rst_dm_en", en3, 0);
    check("mid_rst_cnt", sc3, 0);
    check("mid_rst_wbw", wbw3, 0);
    @(negedge Clk);
    drive_nop();
    dm_rdata = 16'hDEAD;
    Rst = 1'b0;
    // An ALU op must complete cleanly; the abandoned load data never shows.
    ALUResult = 16'h7777; regWrite_in = 1'b1; regAddr_in = 3'd6;
    #1;
    check("post_rst_stall", st3, 0);
    @(posedge Clk); #1;
    check("post_rst_wbd", wbd3, 16'h7777);
    check("post_rst_wba", wba3, 6);
    check("post_rst_cnt", sc3, 0);

    // ---------------- MEM_LAT=1 back-to-back loads ----------------
    do_reset();
    memEnab = 1'b1; sel_mem2reg = 1'b1; regWrite_in = 1'b1;
    memAddr = 10'h001; regAddr_in = 3'd1;
    #1;
    check("b2b_a_stall", st1, 1);
    check("b2b_a_dm_en", en1, 1);
    check("b2b_a_addr", ad1, 10'h001);
    @(negedge Clk);
    dm_rdata = 16'h1111;
    #1;
    check("b2b_a_done_stall", st1, 0);
    @(posedge Clk); #1;
    check("b2b_a_wbd", wbd1, 16'h1111);
    check("b2b_a_wba", wba1, 1);
    @(negedge Clk);
    memAddr = 10'h002; regAddr_in = 3'd2; dm_rdata = '0;
    #1;
    check("b2b_b_stall", st1, 1);
    check("b2b_b_dm_en", en1, 1);
    check("b2b_b_addr", ad1, 10'h002);
    @(negedge Clk);
    dm_rdata = 16'h2222;
    #1;
    check("b2b_b_done_stall", st1, 0);
    @(posedge Clk); #1;
    check("b2b_b_wbd", wbd1, 16'h2222);
    check("b2b_b_wba", wba1, 2);
    check("b2b_b_wbw", wbw1, 1);
    check("b2b_cnt", sc1, 2);

    // ---------------- CNT_W=4 saturation ----------------
    // Held load on MEM_LAT=3: 3 stall cycles out of every 4.
    do_reset();
    memEnab = 1'b1; sel_mem2reg = 1'b1;
    repeat (16) @(posedge Clk);
    #1;
    check("sat_mid", scc, 4'hC);
    repeat (8) @(posedge Clk);   // 6 more stalls would reach 18 unsaturated
    #1;
    check("sat_hit", scc, 4'hF);
    repeat (12) @(posedge Clk);
    #1;
    check("sat_hold", scc, 4'hF);
    @(negedge Clk);
    drive_nop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
